// File: rtl/ultrasonic_ranger_pkg.sv
// Shared definitions for the ultrasonic ranging front end and its consumers.
package ultrasonic_ranger_pkg;

  // Sample width shared with the downstream distance filter.
  localparam int SAMPLE_W = 19;

  // All internal counters use the sample width; no counter can wrap.
  localparam int CNT_W = SAMPLE_W;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    DONE      = 3'd4,
    FAULT     = 3'd5,
    HOLDOFF   = 3'd6
  } state_t;

  // Increment that sticks at the given limit instead of passing it.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                               input logic [CNT_W-1:0] limit);
    logic [CNT_W-1:0] result;
    if (value < limit) begin
      result = value + CNT_W'(1);
    end else begin
      result = limit;
    end
    return result;
  endfunction

endpackage

// File: rtl/ultrasonic_ranger_echo_sync.sv
// Two-flop synchronizer for an asynchronous sensor input with edge detection.
// rise/fall are single-cycle pulses derived from the synchronized level.
module ultrasonic_ranger_echo_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic sync_d_r;

  // Synchronizer chain plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r   <= 1'b0;
      sync_r   <= 1'b0;
      sync_d_r <= 1'b0;
    end else begin
      meta_r   <= async_in;
      sync_r   <= meta_r;
      sync_d_r <= sync_r;
    end
  end

  assign rise = sync_r & ~sync_d_r;
  assign fall = ~sync_r & sync_d_r;

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04-class ultrasonic ranger: issues trigger pulses, times the echo in
// measurement ticks and presents each width as a strobed sample. Lost echoes
// and over-long echoes are reported as a one-cycle timeout pulse.
module ultrasonic_ranger
  import ultrasonic_ranger_pkg::*;
#(
  parameter int TICK_DIV      = 50,
  parameter int TRIG_TICKS    = 10,
  parameter int TIMEOUT_TICKS = 30000,
  parameter int PERIOD_TICKS  = 60000,
  parameter int STROBE_CYC    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                start,
  input  logic                echo,
  output logic                trig,
  output logic [SAMPLE_W-1:0] data_out,
  output logic                data_en,
  output logic                timeout_err,
  output logic                busy
);

  localparam logic [CNT_W-1:0] DIV_LAST     = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_TICKS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_TICKS - 1);
  localparam logic [CNT_W-1:0] PERIOD_LIM   = CNT_W'(PERIOD_TICKS);
  localparam logic [CNT_W-1:0] PERIOD_PRE   = CNT_W'(PERIOD_TICKS - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST  = CNT_W'(STROBE_CYC - 1);

  state_t             state_r;
  state_t             state_next_s;
  logic               state_chg_s;
  logic               echo_rise_s;
  logic               echo_fall_s;

  logic [CNT_W-1:0]   tick_cnt_r;
  logic               tick_s;
  logic [CNT_W-1:0]   step_cnt_r;
  logic [CNT_W-1:0]   width_cnt_r;
  logic [CNT_W-1:0]   width_upd_s;
  logic [CNT_W-1:0]   strobe_cnt_r;
  logic [CNT_W-1:0]   pdiv_cnt_r;
  logic [CNT_W-1:0]   period_cnt_r;
  logic               period_tick_s;
  logic               period_done_s;

  logic               trig_r;
  logic [SAMPLE_W-1:0] data_out_r;
  logic               data_en_r;
  logic               timeout_err_r;
  logic               busy_r;

  ultrasonic_ranger_echo_sync u_echo_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (echo),
    .rise     (echo_rise_s),
    .fall     (echo_fall_s)
  );

  assign state_chg_s   = (state_next_s != state_r);
  assign tick_s        = (tick_cnt_r == DIV_LAST);
  assign period_tick_s = (pdiv_cnt_r == DIV_LAST);
  // The period completes on the tick that would bring the count to the limit,
  // so trigger-to-trigger spacing is exactly PERIOD_TICKS * TICK_DIV cycles.
  assign period_done_s = (period_cnt_r >= PERIOD_LIM) ||
                         (period_tick_s && (period_cnt_r == PERIOD_PRE));

  // Width value after this cycle's tick; the tick coinciding with the echo
  // fall still counts, and the value saturates one below the timeout.
  always_comb begin
    width_upd_s = width_cnt_r;
    if ((state_r == MEASURE) && tick_s) begin
      width_upd_s = sat_inc(width_cnt_r, TIMEOUT_LAST);
    end else begin
      width_upd_s = width_cnt_r;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; echo events take priority over timeout ticks.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start || run) begin
          state_next_s = TRIG;
        end else begin
          state_next_s = IDLE;
        end
      end
      TRIG: begin
        if (tick_s && (step_cnt_r == TRIG_LAST)) begin
          state_next_s = WAIT_RISE;
        end else begin
          state_next_s = TRIG;
        end
      end
      WAIT_RISE: begin
        if (echo_rise_s) begin
          state_next_s = MEASURE;
        end else if (tick_s && (step_cnt_r == TIMEOUT_LAST)) begin
          state_next_s = FAULT;
        end else begin
          state_next_s = WAIT_RISE;
        end
      end
      MEASURE: begin
        if (echo_fall_s) begin
          state_next_s = DONE;
        end else if (tick_s && (width_cnt_r == TIMEOUT_LAST)) begin
          state_next_s = FAULT;
        end else begin
          state_next_s = MEASURE;
        end
      end
      DONE: begin
        if (strobe_cnt_r == STROBE_LAST) begin
          state_next_s = HOLDOFF;
        end else begin
          state_next_s = DONE;
        end
      end
      FAULT: begin
        state_next_s = HOLDOFF;
      end
      HOLDOFF: begin
        if (period_done_s) begin
          if (run) begin
            state_next_s = TRIG;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          state_next_s = HOLDOFF;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Tick prescaler, realigned on every state entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_r <= '0;
    end else if (state_chg_s || tick_s) begin
      tick_cnt_r <= '0;
    end else begin
      tick_cnt_r <= tick_cnt_r + CNT_W'(1);
    end
  end

  // Tick counter for the trigger pulse and the wait for echo rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_r <= '0;
    end else if (state_chg_s) begin
      step_cnt_r <= '0;
    end else if (tick_s && ((state_r == TRIG) || (state_r == WAIT_RISE))) begin
      step_cnt_r <= sat_inc(step_cnt_r, TIMEOUT_LAST);
    end else begin
      step_cnt_r <= step_cnt_r;
    end
  end

  // Echo width counter, cleared on MEASURE entry and held afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      width_cnt_r <= '0;
    end else if ((state_next_s == MEASURE) && (state_r != MEASURE)) begin
      width_cnt_r <= '0;
    end else begin
      width_cnt_r <= width_upd_s;
    end
  end

  // Cycle counter for the strobe phase in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_cnt_r <= '0;
    end else if (state_chg_s) begin
      strobe_cnt_r <= '0;
    end else if (state_r == DONE) begin
      strobe_cnt_r <= strobe_cnt_r + CNT_W'(1);
    end else begin
      strobe_cnt_r <= strobe_cnt_r;
    end
  end

  // Period timer with its own prescaler, restarted at every trigger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pdiv_cnt_r   <= '0;
      period_cnt_r <= '0;
    end else if ((state_next_s == TRIG) && (state_r != TRIG)) begin
      pdiv_cnt_r   <= '0;
      period_cnt_r <= '0;
    end else if (period_tick_s) begin
      pdiv_cnt_r   <= '0;
      period_cnt_r <= sat_inc(period_cnt_r, PERIOD_LIM);
    end else begin
      pdiv_cnt_r   <= pdiv_cnt_r + CNT_W'(1);
      period_cnt_r <= period_cnt_r;
    end
  end

  // Registered outputs; data_out updates on DONE entry, a cycle before data_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_r        <= 1'b0;
      busy_r        <= 1'b0;
      timeout_err_r <= 1'b0;
      data_en_r     <= 1'b0;
      data_out_r    <= '0;
    end else begin
      trig_r        <= (state_next_s == TRIG);
      busy_r        <= (state_next_s != IDLE);
      timeout_err_r <= (state_next_s == FAULT);
      data_en_r     <= (state_r == DONE);
      if ((state_r == MEASURE) && (state_next_s == DONE)) begin
        data_out_r <= width_upd_s;
      end else begin
        data_out_r <= data_out_r;
      end
    end
  end

  assign trig        = trig_r;
  assign busy        = busy_r;
  assign timeout_err = timeout_err_r;
  assign data_en     = data_en_r;
  assign data_out    = data_out_r;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Self-checking bench for ultrasonic_ranger with randomized echo timing and a
// behavioural model of the expected sample or timeout per measurement.
module tb_ultrasonic_ranger;

  localparam int TD = 5;
  localparam int TT = 2;
  localparam int TO = 100;
  localparam int PT = 300;
  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        start;
  logic        echo;
  logic        trig;
  logic [18:0] data_out;
  logic        data_en;
  logic        timeout_err;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  ultrasonic_ranger #(
    .TICK_DIV(TD), .TRIG_TICKS(TT), .TIMEOUT_TICKS(TO),
    .PERIOD_TICKS(PT), .STROBE_CYC(SC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .start(start), .echo(echo),
    .trig(trig), .data_out(data_out), .data_en(data_en),
    .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: echo held high for w clk cycles; -1 means timeout expected.
  function automatic int exp_width(input int w);
    int t;
    if (w > TO * TD) return -1;
    t = w / TD;
    return (t > TO - 1) ? TO - 1 : t;
  endfunction

  // Output monitor: strobe width, data stability, timeout pulse width.
  logic        prev_en = 1'b0;
  logic        prev_to = 1'b0;
  logic [18:0] prev_out = 19'd0;
  int en_len = 0;
  int to_len = 0;
  int en_rises = 0;
  int to_pulses = 0;
  int to_cyc = 0;
  int sample_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (data_en && !prev_en) begin
        en_rises++;
        sample_q.push_back(int'(data_out));
        check("out_stable_pre", data_out, prev_out);
        en_len = 1;
      end else if (data_en) begin
        en_len++;
        check("out_stable_en", data_out, prev_out);
      end else if (prev_en) begin
        check("en_width", en_len, SC);
      end
      if (timeout_err && !prev_to) begin
        to_pulses++;
        to_cyc = cyc;
        to_len = 1;
      end else if (timeout_err) begin
        to_len++;
      end else if (prev_to) begin
        check("to_width", to_len, 1);
      end
    end
    prev_en  = data_en;
    prev_to  = timeout_err;
    prev_out = data_out;
  end

  // One single-shot measurement. rd < 0: no echo; w < 0: echo stuck high.
  task automatic do_meas(input int rd, input int w, input bit poke);
    int s0, t0, n, tfall, e, lat;
    s0 = en_rises;
    t0 = to_pulses;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (!trig && n < 50) begin @(negedge clk); n++; end
    check("trig_rise", trig, 1);
    n = 0;
    while (trig && n < 100) begin @(negedge clk); n++; end
    check("trig_width", n, TT * TD);
    tfall = cyc;
    if (rd >= 0) begin
      repeat (rd) @(negedge clk);
      echo = 1'b1;
      if (w >= 0) begin
        if (poke) begin
          repeat (w / 2) @(negedge clk);
          start = 1'b1;
          @(negedge clk) start = 1'b0;
          repeat (w - w / 2 - 1) @(negedge clk);
        end else begin
          repeat (w) @(negedge clk);
        end
        echo = 1'b0;
      end
    end
    n = 0;
    while (busy && n < 4000) begin @(negedge clk); n++; end
    check("busy_drop", busy, 0);
    echo = 1'b0;
    repeat (20) @(negedge clk);
    check("stay_idle", busy, 0);
    e = (rd < 0 || w < 0) ? -1 : exp_width(w);
    if (e < 0) begin
      check("no_sample", en_rises - s0, 0);
      check("to_count", to_pulses - t0, 1);
      lat = to_cyc - tfall;
      if (rd < 0) check("to_latency", lat, TO * TD);
      else check("to_latency_win", (lat >= rd + 502 && lat <= rd + 504) ? 1 : 0, 1);
    end else begin
      check("sample_count", en_rises - s0, 1);
      check("to_none", to_pulses - t0, 0);
      if (en_rises > s0) check("sample_val", sample_q[$], e);
    end
  endtask

  initial begin
    int s0, n, rise, prev_rise, rd, w, cat;
    int widths[5];
    bit poke;
    widths = '{10, 20, 30, 40, 50};
    rst_n = 1'b0; run = 1'b0; start = 1'b0; echo = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_trig", trig, 0);
    check("rst_data_out", data_out, 0);
    check("rst_data_en", data_en, 0);
    check("rst_timeout", timeout_err, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Basic measurement, lost echo, stuck echo.
    do_meas(250, 200, 1'b0);
    do_meas(-1, 0, 1'b0);
    check("out_kept_after_to", data_out, 40);
    do_meas(100, -1, 1'b0);
    check("out_kept_after_stuck", data_out, 40);

    // Width boundaries around the timeout.
    do_meas(50, 500, 1'b0);
    do_meas(50, 501, 1'b0);
    do_meas(30, 499, 1'b0);
    do_meas(10, 7, 1'b0);

    // Echo edges in IDLE are ignored; start during MEASURE is ignored.
    s0 = en_rises;
    for (int i = 0; i < 6; i++) begin
      echo = ~echo;
      repeat (7) @(negedge clk);
      check("idle_echo_busy", busy, 0);
    end
    echo = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_echo_nosample", en_rises - s0, 0);
    do_meas(40, 123, 1'b1);

    // Randomized single measurements.
    for (int i = 0; i < 10; i++) begin
      cat = $urandom_range(0, 3);
      rd = $urandom_range(0, 400);
      w = 0;
      case (cat)
        0: w = $urandom_range(5, 490);
        1: w = $urandom_range(495, 505);
        2: rd = -1;
        default: w = -1;
      endcase
      poke = (w >= 10) ? 1'($urandom_range(0, 1)) : 1'b0;
      do_meas(rd, w, poke);
    end

    // Continuous mode: fixed trigger period and ordered samples.
    s0 = en_rises;
    prev_rise = 0;
    @(negedge clk) run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (!trig && n < 2000) begin @(negedge clk); n++; end
      check("run_trig", trig, 1);
      rise = cyc;
      if (i > 0) check("trig_period", rise - prev_rise, PT * TD);
      prev_rise = rise;
      n = 0;
      while (trig && n < 100) begin @(negedge clk); n++; end
      check("run_trig_width", n, TT * TD);
      repeat ($urandom_range(5, 200)) @(negedge clk);
      echo = 1'b1;
      repeat (widths[i] * TD + $urandom_range(0, TD - 1)) @(negedge clk);
      echo = 1'b0;
      if (i == 4) run = 1'b0;
    end
    n = 0;
    while (busy && n < 4000) begin @(negedge clk); n++; end
    check("run_busy_drop", busy, 0);
    check("run_sample_count", en_rises - s0, 5);
    for (int i = 0; i < 5; i++) begin
      if (s0 + i < sample_q.size()) check("run_sample_val", sample_q[s0 + i], widths[i]);
    end

    // Asynchronous reset during MEASURE.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (!trig && n < 50) begin @(negedge clk); n++; end
    n = 0;
    while (trig && n < 100) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    echo = 1'b1;
    repeat (60) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_trig", trig, 0);
    check("mid_rst_data_en", data_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_data_out", data_out, 0);
    @(negedge clk) echo = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("post_rst_idle", busy, 0);
    check("post_rst_trig", trig, 0);
    do_meas(20, 77, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
